tlb_nway: RTL and testbench

Parametrised N-way set-associative TLB: the next-generation translation buffer between the processor load/store/fetch path and the Page Table Walker (PTW). It generalises set count and associativity, and adds:
- execute permission
- PTW fault reporting
- true-LRU replacement with invalid-way preference
- a flush channel
- optional ASID tagging

Pages are fixed at 4 KiB; addresses are 32-bit.

---
 rtl/tlb_nway.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_tlb_nway.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_nway.sv
// tlb_nway: N-way set-associative TLB between the load/store/fetch path and
// the page table walker. 4 KiB pages, 32-bit addresses, true-LRU replacement
// with invalid-way preference, flush channel, and execute permission.
// Optional ASID tagging is enabled with the TLB_ASID_EN macro; without it the
// ASID inputs are ignored, matching is VPN-only and every flush clears all.
//
// Handshake rule for every channel (req, resp, flush, ptw_req, ptw_resp):
// a transfer happens on a rising edge where valid and ready are both high;
// the producer holds valid and payload stable until that edge, and valid
// never depends combinationally on ready.
module tlb_nway #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int ASID_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       vaddr_i,
  input  logic [1:0]        access_type_i,
  input  logic [ASID_W-1:0] asid_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       paddr_o,
  output logic              hit_o,
  output logic              fault_o,
  input  logic              flush_valid_i,
  input  logic              flush_all_i,
  input  logic [ASID_W-1:0] flush_asid_i,
  output logic              flush_ready_o,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [31:0]       ptw_vaddr_o,
  input  logic              ptw_resp_valid_i,
  output logic              ptw_resp_ready_o,
  input  logic [31:0]       ptw_pte_i,
  input  logic              ptw_fault_i,
  output logic [2:0]        dbg_state_o
);

  localparam int IDX_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 0;
  localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
  localparam int AGE_W = $clog2(NUM_WAYS);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_PTW_REQ, S_PTW_WAIT, S_FILL, S_RESP
  } state_t;

  // Permission check: R for read, W for write, X for execute, type 11 faults.
  function automatic logic perm_fault(input logic [1:0] ty, input logic [2:0] xwr);
    case (ty)
      2'b00:   return !xwr[0];
      2'b01:   return !xwr[1];
      2'b10:   return !xwr[2];
      default: return 1'b1;
    endcase
  endfunction

  // Entry storage
  logic             ent_valid [NUM_SETS][NUM_WAYS];
  logic [19:0]      ent_vpn   [NUM_SETS][NUM_WAYS];
  logic [19:0]      ent_ppn   [NUM_SETS][NUM_WAYS];
  logic [2:0]       ent_perm  [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] ent_age   [NUM_SETS][NUM_WAYS];
`ifdef TLB_ASID_EN
  logic              ent_g    [NUM_SETS][NUM_WAYS];
  logic [ASID_W-1:0] ent_asid [NUM_SETS][NUM_WAYS];
  logic [ASID_W-1:0] req_asid;
`else
  logic unused_asid;
  assign unused_asid = ^{asid_i, flush_asid_i, ptw_pte_i[3]};
`endif
  logic unused_pte;
  assign unused_pte = ^ptw_pte_i[11:4];

  // Captured request and walk result
  logic [19:0] req_vpn;
  logic [11:0] req_off;
  logic [1:0]  req_type;
  logic [19:0] pte_ppn;
  logic [2:0]  pte_perm;
  logic        pte_g;
  logic        pte_fault;
  logic [IW-1:0] req_set;

  generate
    if (NUM_SETS > 1) begin : g_idx
      assign req_set = req_vpn[IW-1:0];
    end else begin : g_noidx
      assign req_set = '0;
    end
  endgenerate

  // FSM and registered outputs
  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        resp_valid_d, hit_d, fault_d, ptw_req_valid_d, ptw_resp_ready_d;
  logic [31:0] paddr_d, ptw_vaddr_d;

  logic req_fire, flush_fire, ptw_resp_fire;
  assign req_ready_o   = rdy_q && !flush_valid_i;
  assign flush_ready_o = rdy_q;
  assign req_fire      = req_valid_i && req_ready_o;
  assign flush_fire    = flush_valid_i && rdy_q;
  assign ptw_resp_fire = ptw_resp_valid_i && ptw_resp_ready_o;
  assign dbg_state_o   = state_q;

  // Lookup and victim selection on the captured request's set
  logic [NUM_WAYS-1:0] lk_match;
  logic                lk_hit;
  logic [AGE_W-1:0]    lk_way, lk_age, vic_way;
  logic [19:0]         lk_ppn;
  logic [2:0]          lk_perm;
  logic                have_inv;

  // Tag compare, hit way select and victim choice
  always_comb begin
    lk_match = '0;
    lk_hit   = 1'b0;
    lk_way   = '0;
    have_inv = 1'b0;
    vic_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      lk_match[w] = ent_valid[req_set][w] && (ent_vpn[req_set][w] == req_vpn);
`ifdef TLB_ASID_EN
      lk_match[w] = lk_match[w] && (ent_g[req_set][w] || ent_asid[req_set][w] == req_asid);
`endif
      if (lk_match[w]) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (ent_age[req_set][w] == AGE_MAX) vic_way = AGE_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!ent_valid[req_set][w]) begin
        have_inv = 1'b1;
        vic_way  = AGE_W'(w);
      end
    end
    lk_age  = ent_age[req_set][lk_way];
    lk_ppn  = ent_ppn[req_set][lk_way];
    lk_perm = ent_perm[req_set][lk_way];
  end

  logic             lru_upd, install;
  logic [AGE_W-1:0] upd_way, upd_old;
  logic             lk_fault, fill_fault;
  assign lk_fault   = perm_fault(req_type, lk_perm);
  assign fill_fault = perm_fault(req_type, pte_perm);

  // Next state, next registered outputs and table update strobes
  always_comb begin
    state_d          = state_q;
    rdy_d            = rdy_q;
    resp_valid_d     = resp_valid_o;
    hit_d            = hit_o;
    fault_d          = fault_o;
    paddr_d          = paddr_o;
    ptw_req_valid_d  = ptw_req_valid_o;
    ptw_vaddr_d      = ptw_vaddr_o;
    ptw_resp_ready_d = ptw_resp_ready_o;
    lru_upd          = 1'b0;
    install          = 1'b0;
    upd_way          = lk_way;
    upd_old          = lk_age;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          rdy_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lk_hit) begin
          lru_upd      = 1'b1;
          resp_valid_d = 1'b1;
          hit_d        = 1'b1;
          fault_d      = lk_fault;
          paddr_d      = lk_fault ? 32'h0 : {lk_ppn, req_off};
          state_d      = S_RESP;
        end else begin
          ptw_req_valid_d = 1'b1;
          ptw_vaddr_d     = {req_vpn, 12'h000};
          state_d         = S_PTW_REQ;
        end
      end
      S_PTW_REQ: begin
        if (ptw_req_ready_i) begin
          ptw_req_valid_d  = 1'b0;
          ptw_resp_ready_d = 1'b1;
          state_d          = S_PTW_WAIT;
        end
      end
      S_PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          ptw_resp_ready_d = 1'b0;
          state_d          = S_FILL;
        end
      end
      S_FILL: begin
        resp_valid_d = 1'b1;
        hit_d        = 1'b0;
        if (pte_fault) begin
          fault_d = 1'b1;
          paddr_d = 32'h0;
        end else begin
          install = 1'b1;
          lru_upd = 1'b1;
          upd_way = vic_way;
          upd_old = AGE_MAX;
          fault_d = fill_fault;
          paddr_d = fill_fault ? 32'h0 : {pte_ppn, req_off};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          rdy_d        = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      rdy_q            <= 1'b1;
      resp_valid_o     <= 1'b0;
      hit_o            <= 1'b0;
      fault_o          <= 1'b0;
      paddr_o          <= 32'h0;
      ptw_req_valid_o  <= 1'b0;
      ptw_vaddr_o      <= 32'h0;
      ptw_resp_ready_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      rdy_q            <= rdy_d;
      resp_valid_o     <= resp_valid_d;
      hit_o            <= hit_d;
      fault_o          <= fault_d;
      paddr_o          <= paddr_d;
      ptw_req_valid_o  <= ptw_req_valid_d;
      ptw_vaddr_o      <= ptw_vaddr_d;
      ptw_resp_ready_o <= ptw_resp_ready_d;
    end
  end

  // Capture the accepted request and the walker result
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_vpn  <= vaddr_i[31:12];
      req_off  <= vaddr_i[11:0];
      req_type <= access_type_i;
`ifdef TLB_ASID_EN
      req_asid <= asid_i;
`endif
    end
    if (ptw_resp_fire) begin
      pte_ppn   <= ptw_pte_i[31:12];
      pte_g     <= ptw_pte_i[3];
      pte_perm  <= ptw_pte_i[2:0];
      pte_fault <= ptw_fault_i;
    end
  end

  // Table maintenance: flush, LRU ages and fills
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          ent_valid[s][w] <= 1'b0;
          ent_age[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (flush_fire) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef TLB_ASID_EN
            if (flush_all_i || (ent_asid[s][w] == flush_asid_i && !ent_g[s][w]))
              ent_valid[s][w] <= 1'b0;
`else
            ent_valid[s][w] <= 1'b0;
`endif
          end
        end
      end
      if (lru_upd) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_W'(w) == upd_way)
            ent_age[req_set][w] <= '0;
          else if (ent_age[req_set][w] < upd_old)
            ent_age[req_set][w] <= ent_age[req_set][w] + 1'b1;
        end
      end
      if (install) begin
        ent_valid[req_set][vic_way] <= 1'b1;
        ent_vpn[req_set][vic_way]   <= req_vpn;
        ent_ppn[req_set][vic_way]   <= pte_ppn;
        ent_perm[req_set][vic_way]  <= pte_perm;
`ifdef TLB_ASID_EN
        ent_g[req_set][vic_way]     <= pte_g;
        ent_asid[req_set][vic_way]  <= req_asid;
`endif
      end
    end
  end

`ifndef TLB_ASID_EN
  logic unused_g;
  assign unused_g = pte_g ^ have_inv;
`else
  logic unused_inv;
  assign unused_inv = have_inv;
`endif

endmodule

// File: tb/tb_tlb_nway.sv
// Directed testbench for tlb_nway with default parameters (16 sets, 4 ways).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_tlb_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] vaddr_i = '0;
  logic [1:0]  access_type_i = '0;
  logic [8:0]  asid_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] paddr_o;
  logic        hit_o, fault_o;
  logic        flush_valid_i = 1'b0;
  logic        flush_all_i = 1'b0;
  logic [8:0]  flush_asid_i = '0;
  logic        flush_ready_o;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i = 1'b0;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i = 1'b0;
  logic        ptw_resp_ready_o;
  logic [31:0] ptw_pte_i = '0;
  logic        ptw_fault_i = 1'b0;
  logic [2:0]  dbg_state_o;

`ifdef TLB_ASID_EN
  localparam bit ASID_ON = 1'b1;
`else
  localparam bit ASID_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  tlb_nway dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .vaddr_i(vaddr_i), .access_type_i(access_type_i), .asid_i(asid_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .paddr_o(paddr_o), .hit_o(hit_o), .fault_o(fault_o),
    .flush_valid_i(flush_valid_i), .flush_all_i(flush_all_i),
    .flush_asid_i(flush_asid_i), .flush_ready_o(flush_ready_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_vaddr_o(ptw_vaddr_o), .ptw_resp_valid_i(ptw_resp_valid_i),
    .ptw_resp_ready_o(ptw_resp_ready_o), .ptw_pte_i(ptw_pte_i),
    .ptw_fault_i(ptw_fault_i), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"},  32'(req_ready_o), 32'd1);
    check({tag, "_flush_rdy"},  32'(flush_ready_o), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_hit"},        32'(hit_o), 32'd0);
    check({tag, "_fault"},      32'(fault_o), 32'd0);
    check({tag, "_ptw_req"},    32'(ptw_req_valid_o), 32'd0);
    check({tag, "_ptw_rsp_rdy"},32'(ptw_resp_ready_o), 32'd0);
    check({tag, "_paddr"},      paddr_o, 32'h0);
    check({tag, "_ptw_vaddr"},  ptw_vaddr_o, 32'h0);
  endtask

  // Present a request and hold it until accepted
  task automatic issue(input logic [31:0] va, input logic [1:0] ty, input logic [8:0] asid);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; vaddr_i = va; access_type_i = ty; asid_i = asid;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  // Serve a walk if one appears, then check and consume the response
  task automatic finish_req(input logic [31:0] va, input bit exp_miss, input logic [31:0] pte,
                            input logic pf, input logic exp_flt, input logic [31:0] exp_pa);
    int n;
    logic ptw_seen;
    logic [31:0] exp_v;
    exp_q.push_back(exp_pa);
    ptw_seen = 1'b0;
    @(negedge clk);
    n = 0;
    while (!resp_valid_o && !ptw_req_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_lat", 32'(n), 32'd1);
    if (ptw_req_valid_o) begin
      ptw_seen = 1'b1;
      check("ptw_vaddr", ptw_vaddr_o, {va[31:12], 12'h000});
      @(negedge clk);
      check("ptw_hold", 32'(ptw_req_valid_o), 32'd1);
      ptw_req_ready_i = 1'b1;
      @(posedge clk); #1;
      ptw_req_ready_i = 1'b0;
      @(negedge clk);
      check("ptw_req_drop", 32'(ptw_req_valid_o), 32'd0);
      check("ptw_resp_ready", 32'(ptw_resp_ready_o), 32'd1);
      ptw_resp_valid_i = 1'b1; ptw_pte_i = pte; ptw_fault_i = pf;
      @(posedge clk); #1;
      ptw_resp_valid_i = 1'b0; ptw_fault_i = 1'b0;
      @(negedge clk);
      check("ptw_resp_ready_drop", 32'(ptw_resp_ready_o), 32'd0);
      n = 0;
      while (!resp_valid_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("fill_lat", 32'(n), 32'd1);
    end
    check("ptw_seen", 32'(ptw_seen), 32'(exp_miss));
    check("resp_valid", 32'(resp_valid_o), 32'd1);
    check("hit", 32'(hit_o), 32'(!exp_miss));
    check("fault", 32'(fault_o), 32'(exp_flt));
    exp_v = exp_q.pop_front();
    check("paddr", paddr_o, exp_v);
    check("busy", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check("resp_hold", paddr_o, exp_v);
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    @(negedge clk);
    check("resp_done", 32'(resp_valid_o), 32'd0);
    check("ready_back", 32'(req_ready_o), 32'd1);
  endtask

  task automatic do_req(input logic [31:0] va, input logic [1:0] ty, input logic [8:0] asid,
                        input bit exp_miss, input logic [31:0] pte, input logic pf,
                        input logic exp_flt, input logic [31:0] exp_pa);
    issue(va, ty, asid);
    finish_req(va, exp_miss, pte, pf, exp_flt, exp_pa);
  endtask

  task automatic do_flush(input logic all, input logic [8:0] asid);
    @(negedge clk);
    check("flush_ready", 32'(flush_ready_o), 32'd1);
    flush_valid_i = 1'b1; flush_all_i = all; flush_asid_i = asid;
    @(posedge clk); #1;
    flush_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    check("reset_state", 32'(dbg_state_o), 32'd0);
    rst = 1'b0;

    // Cold miss then hit on the same page
    do_req(32'h12345678, 2'b00, 9'd0, 1'b1, 32'hABCDE003, 1'b0, 1'b0, 32'hABCDE678);
    do_req(32'h12345678, 2'b00, 9'd0, 1'b0, 32'h0,       1'b0, 1'b0, 32'hABCDE678);
    // Permissions: PTE 003 is R|W, no X
    do_req(32'h12345ABC, 2'b01, 9'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hABCDEABC);
    do_req(32'h12345000, 2'b10, 9'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    do_req(32'h12345000, 2'b11, 9'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    // Read-only page: write faults on hit
    do_req(32'h0000A123, 2'b00, 9'd0, 1'b1, 32'h55555001, 1'b0, 1'b0, 32'h55555123);
    do_req(32'h0000A124, 2'b01, 9'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0);
    // Execute page X|R
    do_req(32'h00007010, 2'b10, 9'd0, 1'b1, 32'h00001005, 1'b0, 1'b0, 32'h00001010);
    do_req(32'h00007020, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00001020);
    // Write-fault on fill: entry still installed, later read hits
    do_req(32'h00008040, 2'b01, 9'd0, 1'b1, 32'h00002001, 1'b0, 1'b1, 32'h0);
    do_req(32'h00008040, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00002040);
    // PTW fault: nothing installed, next access walks again
    do_req(32'h00033444, 2'b00, 9'd0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h0);
    do_req(32'h00033444, 2'b00, 9'd0, 1'b1, 32'h0000C001, 1'b0, 1'b0, 32'h0000C444);

    // LRU in set 0: fill A..D, touch A, fill E evicts B
    do_req(32'h00100000, 2'b00, 9'd0, 1'b1, 32'h0A000007, 1'b0, 1'b0, 32'h0A000000);
    do_req(32'h00200000, 2'b00, 9'd0, 1'b1, 32'h0B000007, 1'b0, 1'b0, 32'h0B000000);
    do_req(32'h00300000, 2'b00, 9'd0, 1'b1, 32'h0C000007, 1'b0, 1'b0, 32'h0C000000);
    do_req(32'h00400000, 2'b00, 9'd0, 1'b1, 32'h0D000007, 1'b0, 1'b0, 32'h0D000000);
    do_req(32'h00100004, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0A000004);
    do_req(32'h00500000, 2'b00, 9'd0, 1'b1, 32'h0E000007, 1'b0, 1'b0, 32'h0E000000);
    do_req(32'h00100010, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0A000010);
    do_req(32'h00300010, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0C000010);
    do_req(32'h00400010, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0D000010);
    do_req(32'h00500010, 2'b00, 9'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0E000010);
    do_req(32'h00200010, 2'b00, 9'd0, 1'b1, 32'h0B000007, 1'b0, 1'b0, 32'h0B000010);

    // Flush: ASID 1 page, ASID 2 page, global page (G=1, installed by ASID 1)
    do_req(32'h00061100, 2'b00, 9'd1, 1'b1, 32'h61000001, 1'b0, 1'b0, 32'h61000100);
    do_req(32'h00062200, 2'b00, 9'd2, 1'b1, 32'h62000001, 1'b0, 1'b0, 32'h62000200);
    do_req(32'h00063300, 2'b00, 9'd1, 1'b1, 32'h63000009, 1'b0, 1'b0, 32'h63000300);
    do_flush(1'b0, 9'd1);
    do_req(32'h00061104, 2'b00, 9'd1, 1'b1,     32'h61000001, 1'b0, 1'b0, 32'h61000104);
    do_req(32'h00062204, 2'b00, 9'd2, !ASID_ON, 32'h62000001, 1'b0, 1'b0, 32'h62000204);
    do_req(32'h00063304, 2'b00, 9'd3, !ASID_ON, 32'h63000009, 1'b0, 1'b0, 32'h63000304);
    do_flush(1'b1, 9'd0);
    do_req(32'h00062208, 2'b00, 9'd2, 1'b1, 32'h62000001, 1'b0, 1'b0, 32'h62000208);
    do_req(32'h00063308, 2'b00, 9'd3, 1'b1, 32'h63000009, 1'b0, 1'b0, 32'h63000308);

    // Flush and request in the same cycle: flush wins, request sees empty TLB
    @(negedge clk);
    flush_valid_i = 1'b1; flush_all_i = 1'b1; flush_asid_i = 9'd0;
    req_valid_i = 1'b1; vaddr_i = 32'h00062210; access_type_i = 2'b00; asid_i = 9'd2;
    #1;
    check("flush_blocks_req", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_valid_i = 1'b0;
    #1;
    check("req_after_flush", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    finish_req(32'h00062210, 1'b1, 32'h62000001, 1'b0, 1'b0, 32'h62000210);

    // Reset while waiting for the walker
    issue(32'h00077000, 2'b00, 9'd0);
    n = 0;
    @(negedge clk);
    while (!ptw_req_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_ptw_req", 32'(ptw_req_valid_o), 32'd1);
    ptw_req_ready_i = 1'b1;
    @(posedge clk); #1;
    ptw_req_ready_i = 1'b0;
    @(negedge clk);
    check("rst_in_wait", 32'(ptw_resp_ready_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    ptw_resp_valid_i = 1'b1; ptw_pte_i = 32'h12312001;
    repeat (2) begin
      @(negedge clk);
      check("late_resp_ignored", 32'(ptw_resp_ready_o), 32'd0);
    end
    ptw_resp_valid_i = 1'b0;
    check("late_no_resp", 32'(resp_valid_o), 32'd0);
    check("late_idle", 32'(dbg_state_o), 32'd0);
    do_req(32'h00077ABC, 2'b00, 9'd0, 1'b1, 32'h77700001, 1'b0, 1'b0, 32'h77700ABC);
    // The earlier entries were cleared by reset
    do_req(32'h12345678, 2'b00, 9'd0, 1'b1, 32'hABCDE003, 1'b0, 1'b0, 32'hABCDE678);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
